tx_sym_sched: RTL and testbench

Symbol scheduler and controller for the 4x-oversampled BPSK transmit pulse-shaping filter. It sources one symbol per baud period, from either an internal PRBS9 generator or a small host-loaded symbol FIFO, and drives the filter's `enable` and `symbol` inputs. It holds each symbol stable for exactly USAMPLE clocks and provides start/stop sequencing with clean symbol-boundary termination. It also reports underrun and symbol-count status to the host side.

---
 rtl/tx_sym_sched.sv | 203 ++++++++++++++++++++
 tb/tb_tx_sym_sched.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_sym_sched.sv
// Symbol scheduler for the 4x-oversampled BPSK pulse-shaping filter: sources one
// symbol per baud period from PRBS9 or a host-loaded FIFO, with boundary-clean stop.
module tx_sym_sched #(
  parameter int         USAMPLE    = 4,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [8:0] PRBS_SEED  = 9'h1FF,
  localparam int        PW         = $clog2(USAMPLE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          src_sel,
  input  logic          wr_valid,
  input  logic          wr_data,
  output logic          wr_ready,
  output logic          filt_enable,
  output logic          filt_symbol,
  output logic [PW-1:0] phase,
  output logic          sym_strobe,
  output logic          busy,
  output logic          underrun,
  output logic [15:0]   sym_count
);

  localparam int            AW         = $clog2(FIFO_DEPTH);
  localparam int            CW         = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(USAMPLE - 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [PW-1:0]   phase_r, next_phase_s;
  logic            src_r;
  logic            stop_pend_r;
  logic [8:0]      lfsr_r;
  logic            filt_enable_r, filt_symbol_r, sym_strobe_r, busy_r, underrun_r;
  logic [15:0]     sym_count_r;
  logic            mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r, count_s;
  logic            wr_ready_r;
  logic            empty_s, push_s, pop_s, load_s, bound_s, clr_s, set_ur_s, sym_s;

  assign empty_s = (count_r == {CW{1'b0}});
  assign push_s  = wr_valid && (count_r != FULL_CNT);
  assign sym_s   = src_r ? mem_r[rd_ptr_r] : lfsr_r[8];

  // Next-state and per-cycle action decode
  always_comb begin
    state_s  = state_r;
    load_s   = 1'b0;
    bound_s  = 1'b0;
    clr_s    = 1'b0;
    set_ur_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          clr_s   = 1'b1;
          state_s = S_ARM;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ARM: begin
        if (stop) begin
          state_s = S_IDLE;
        end else if (src_r && empty_s) begin
          set_ur_s = 1'b1;
          state_s  = S_IDLE;
        end else begin
          load_s  = 1'b1;
          state_s = S_RUN;
        end
      end
      S_RUN: begin
        if (phase_r == LAST_PHASE) begin
          bound_s = 1'b1;
          // A pending stop wins over underrun: the run ends cleanly without a pop.
          if (stop || stop_pend_r) begin
            state_s = S_IDLE;
          end else if (src_r && empty_s) begin
            set_ur_s = 1'b1;
            state_s  = S_IDLE;
          end else begin
            load_s  = 1'b1;
            state_s = S_RUN;
          end
        end else begin
          state_s = S_RUN;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    pop_s = load_s && src_r;
  end

  // Phase that the next cycle will show
  always_comb begin
    if ((state_s == S_RUN) && (state_r == S_RUN)) begin
      next_phase_s = phase_r + PW'(1);
    end else begin
      next_phase_s = {PW{1'b0}};
    end
  end

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    if (push_s && !pop_s) begin
      count_s = count_r + CW'(1);
    end else if (!push_s && pop_s) begin
      count_s = count_r - CW'(1);
    end else begin
      count_s = count_r;
    end
  end

  // Scheduler state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= S_IDLE;
      phase_r       <= {PW{1'b0}};
      src_r         <= 1'b0;
      stop_pend_r   <= 1'b0;
      lfsr_r        <= PRBS_SEED;
      filt_enable_r <= 1'b0;
      filt_symbol_r <= 1'b0;
      sym_strobe_r  <= 1'b0;
      busy_r        <= 1'b0;
      underrun_r    <= 1'b0;
      sym_count_r   <= 16'd0;
    end else begin
      state_r       <= state_s;
      phase_r       <= next_phase_s;
      stop_pend_r   <= (state_r == S_RUN) && (state_s == S_RUN) && (stop_pend_r || stop);
      filt_enable_r <= (state_s == S_RUN);
      busy_r        <= (state_s != S_IDLE);
      sym_strobe_r  <= (state_s == S_RUN) && (next_phase_s == LAST_PHASE);
      if (load_s) begin
        filt_symbol_r <= sym_s;
      end
      if (clr_s) begin
        src_r       <= src_sel;
        lfsr_r      <= PRBS_SEED;
        sym_count_r <= 16'd0;
        underrun_r  <= 1'b0;
      end else begin
        if (set_ur_s) begin
          underrun_r <= 1'b1;
        end
        if (load_s && !src_r) begin
          lfsr_r <= {lfsr_r[7:0], lfsr_r[8] ^ lfsr_r[4]};
        end
        if (bound_s) begin
          sym_count_r <= sym_count_r + 16'd1;
        end
      end
    end
  end

  // FIFO pointers, occupancy and ready flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      wr_ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r    <= count_s;
      wr_ready_r <= (count_s != FULL_CNT);
    end
  end

  // FIFO storage; contents are don't-care once the pointers are reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  assign wr_ready    = wr_ready_r;
  assign filt_enable = filt_enable_r;
  assign filt_symbol = filt_symbol_r;
  assign phase       = phase_r;
  assign sym_strobe  = sym_strobe_r;
  assign busy        = busy_r;
  assign underrun    = underrun_r;
  assign sym_count   = sym_count_r;

endmodule

// File: tb/tb_tx_sym_sched.sv
// Bench for tx_sym_sched: scenario tasks plus randomized runs checked against a
// run-level model (symbol lists, FIFO queue, boundary arithmetic).
module tb_tx_sym_sched;
  localparam int US    = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, stop = 1'b0, src_sel = 1'b0, wr_valid = 1'b0, wr_data = 1'b0;
  logic        wr_ready, filt_enable, filt_symbol, sym_strobe, busy, underrun;
  logic [1:0]  phase;
  logic [15:0] sym_count;

  int total = 0;
  int bad   = 0;

  bit model_q[$];
  bit got_q[$];
  int c_en, c_strobe, c_proto, c_rise, c_busy, c_endk;
  bit c_to;

  tx_sym_sched #(.USAMPLE(US), .FIFO_DEPTH(DEPTH), .PRBS_SEED(9'h1FF)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .src_sel(src_sel),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .filt_enable(filt_enable), .filt_symbol(filt_symbol), .phase(phase),
    .sym_strobe(sym_strobe), .busy(busy), .underrun(underrun), .sym_count(sym_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n-th PRBS9 symbol of a run: seed stepped n times, MSB taken
  function automatic bit prbs_sym(input int n);
    logic [8:0] l;
    l = 9'h1FF;
    for (int i = 0; i < n; i++) l = {l[7:0], l[8] ^ l[4]};
    return l[8];
  endfunction

  task automatic write_sym(input bit d, output bit rdy);
    rdy = wr_ready;
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(d);
  endtask

  // Pulses start, then observes the run until busy drops; records symbols and protocol slips
  task automatic capture(input bit src, input int stop_k, input int restart_k, input int budget);
    int k;
    int idx;
    bit cur;
    got_q.delete();
    c_en = 0; c_strobe = 0; c_proto = 0; c_rise = -1; c_busy = 0; c_endk = -1; c_to = 1'b0;
    idx = 0; cur = 1'b0;
    src_sel = src;
    start = 1'b1;
    tick();
    start = 1'b0;
    src_sel = 1'($urandom_range(1, 0));
    k = 0;
    forever begin
      if (busy) c_busy++;
      if (sym_count !== 16'(c_strobe)) c_proto++;
      if (filt_enable) begin
        if (c_rise < 0) c_rise = k + 1;
        if (phase !== 2'(idx % US)) c_proto++;
        if (idx % US == 0) begin
          got_q.push_back(filt_symbol);
          cur = filt_symbol;
        end else if (filt_symbol !== cur) c_proto++;
        if (sym_strobe !== (idx % US == US - 1)) c_proto++;
        idx++;
        c_en++;
      end else if (phase !== 2'd0 || sym_strobe !== 1'b0) c_proto++;
      if (sym_strobe) c_strobe++;
      if (k > 0 && !busy) begin
        c_endk = k;
        break;
      end
      if (k >= budget) begin
        c_to = 1'b1;
        break;
      end
      stop  = (k == stop_k);
      start = (k == restart_k);
      tick();
      k++;
    end
    stop = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    total++;
    if ({filt_enable, filt_symbol, phase, sym_strobe, busy, underrun, wr_ready, sym_count} !== {8'b0000_0001, 16'd0}) begin
      bad++;
      $display("FAIL reset_state got=%h exp=%h", {filt_enable, filt_symbol, phase, sym_strobe, busy, underrun, wr_ready, sym_count}, {8'b0000_0001, 16'd0});
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_prbs_run();
    int mis;
    logic [9:0] first10;
    capture(1'b0, 40, -1, 100);
    mis = 0;
    first10 = 10'd0;
    foreach (got_q[i]) begin
      if (got_q[i] !== prbs_sym(i)) mis++;
      if (i < 10) first10[9 - i] = got_q[i];
    end
    total++; if (c_to) begin bad++; $display("FAIL prbs_timeout got=1 exp=0"); end
    total++; if (c_rise !== 2) begin bad++; $display("FAIL prbs_rise got=%0d exp=2", c_rise); end
    total++; if (got_q.size() !== 10) begin bad++; $display("FAIL prbs_nsym got=%0d exp=10", got_q.size()); end
    total++; if (mis !== 0) begin bad++; $display("FAIL prbs_symbols got=%0d_wrong exp=0_wrong", mis); end
    total++; if (first10 !== 10'b11_1111_1110) begin bad++; $display("FAIL prbs_first10 got=%b exp=1111111110", first10); end
    total++; if (c_en !== 40) begin bad++; $display("FAIL prbs_en_cycles got=%0d exp=40", c_en); end
    total++; if (sym_count !== 16'd10 || c_strobe !== 10) begin bad++; $display("FAIL prbs_count got=%0d/%0d exp=10/10", sym_count, c_strobe); end
    total++; if (c_endk !== 41) begin bad++; $display("FAIL prbs_end got=%0d exp=41", c_endk); end
    total++; if (c_proto !== 0) begin bad++; $display("FAIL prbs_protocol got=%0d exp=0", c_proto); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL prbs_underrun got=%b exp=0", underrun); end
  endtask

  task automatic test_fifo_run();
    bit rdy;
    int rmis;
    bit pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int mis;
    rmis = 0;
    foreach (pat[i]) begin
      write_sym(pat[i], rdy);
      if (rdy !== 1'b1) rmis++;
    end
    model_q.delete();
    capture(1'b1, -1, -1, 60);
    mis = 0;
    foreach (got_q[i]) if (i < 4 && got_q[i] !== pat[i]) mis++;
    total++; if (rmis !== 0) begin bad++; $display("FAIL fifo_wr_ready got=%0d_low exp=0_low", rmis); end
    total++; if (got_q.size() !== 4 || mis !== 0) begin bad++; $display("FAIL fifo_symbols got=%0d_syms/%0d_wrong exp=4/0", got_q.size(), mis); end
    total++; if (c_en !== 16) begin bad++; $display("FAIL fifo_en_cycles got=%0d exp=16", c_en); end
    total++; if (underrun !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL fifo_underrun got=%b/%b exp=1/0", underrun, busy); end
    total++; if (sym_count !== 16'd4) begin bad++; $display("FAIL fifo_count got=%0d exp=4", sym_count); end
    total++; if (c_proto !== 0 || c_to) begin bad++; $display("FAIL fifo_protocol got=%0d/%b exp=0/0", c_proto, c_to); end
  endtask

  task automatic test_empty_start();
    capture(1'b1, -1, -1, 20);
    total++; if (c_busy !== 1) begin bad++; $display("FAIL empty_busy got=%0d exp=1", c_busy); end
    total++; if (c_en !== 0) begin bad++; $display("FAIL empty_enable got=%0d exp=0", c_en); end
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL empty_underrun got=%b exp=1", underrun); end
    total++; if (sym_count !== 16'd0) begin bad++; $display("FAIL empty_count got=%0d exp=0", sym_count); end
  endtask

  task automatic test_full_fifo();
    bit rdy;
    int rmis;
    int mis;
    rmis = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      write_sym(1'($urandom_range(1, 0)), rdy);
      if (rdy !== (i < DEPTH)) rmis++;
    end
    total++; if (rmis !== 0) begin bad++; $display("FAIL full_ready_seq got=%0d_wrong exp=0_wrong", rmis); end
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", wr_ready); end
    capture(1'b1, -1, -1, 60);
    mis = 0;
    foreach (got_q[i]) if (i < DEPTH && got_q[i] !== model_q[i]) mis++;
    total++; if (got_q.size() !== DEPTH || mis !== 0) begin bad++; $display("FAIL full_symbols got=%0d_syms/%0d_wrong exp=8/0", got_q.size(), mis); end
    total++; if (underrun !== 1'b1 || sym_count !== 16'd8) begin bad++; $display("FAIL full_end got=%b/%0d exp=1/8", underrun, sym_count); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL full_drain_ready got=%b exp=1", wr_ready); end
    model_q.delete();
  endtask

  task automatic test_stop_timing();
    int stop_at[2] = '{9, 12};
    int restart_at[2] = '{5, 10};
    for (int t = 0; t < 2; t++) begin
      capture(1'b0, stop_at[t], restart_at[t], 60);
      total++;
      if (got_q.size() !== 3 || c_endk !== 13 || sym_count !== 16'd3 || c_proto !== 0) begin
        bad++;
        $display("FAIL stop_k%0d got=%0d_syms/end%0d/cnt%0d/proto%0d exp=3/13/3/0", stop_at[t], got_q.size(), c_endk, sym_count, c_proto);
      end
      total++;
      if (got_q.size() == 3 && {got_q[0], got_q[1], got_q[2]} !== {prbs_sym(0), prbs_sym(1), prbs_sym(2)}) begin
        bad++;
        $display("FAIL stop_syms_k%0d got=%b%b%b exp=%b%b%b", stop_at[t], got_q[0], got_q[1], got_q[2], prbs_sym(0), prbs_sym(1), prbs_sym(2));
      end
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_restart_ignored got=%b exp=0", busy); end
    end
    capture(1'b0, 0, -1, 20);
    total++; if (c_en !== 0 || c_endk !== 1 || underrun !== 1'b0) begin bad++; $display("FAIL arm_stop got=%0d/%0d/%b exp=0/1/0", c_en, c_endk, underrun); end
  endtask

  task automatic test_back_to_back();
    capture(1'b0, 5, -1, 40);
    total++; if (c_endk !== 9 || c_rise !== 2) begin bad++; $display("FAIL b2b_first got=%0d/%0d exp=9/2", c_endk, c_rise); end
    capture(1'b0, 5, -1, 40);
    total++; if (c_rise !== 2 || got_q.size() !== 2) begin bad++; $display("FAIL b2b_restart got=%0d/%0d exp=2/2", c_rise, got_q.size()); end
  endtask

  task automatic test_reset_midrun();
    bit rdy;
    int n;
    for (int i = 0; i < 3; i++) write_sym(1'b1, rdy);
    src_sel = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(filt_enable && phase == 2'd2) && n < 20) begin
      tick();
      n++;
    end
    total++; if (n >= 20) begin bad++; $display("FAIL midrun_reach_phase2 got=timeout exp=phase2"); end
    rst = 1'b0;
    tick();
    total++;
    if ({filt_enable, filt_symbol, phase, sym_strobe, busy, underrun, wr_ready, sym_count} !== {8'b0000_0001, 16'd0}) begin
      bad++;
      $display("FAIL midrun_reset got=%h exp=%h", {filt_enable, filt_symbol, phase, sym_strobe, busy, underrun, wr_ready, sym_count}, {8'b0000_0001, 16'd0});
    end
    rst = 1'b1;
    model_q.delete();
    tick();
    capture(1'b1, -1, -1, 20);
    total++; if (underrun !== 1'b1 || c_en !== 0) begin bad++; $display("FAIL midrun_fifo_empty got=%b/%0d exp=1/0", underrun, c_en); end
  endtask

  task automatic test_random();
    bit rdy;
    bit d;
    bit src;
    int nw, stop_k, qlen, nexp, mis, rmis;
    bit uexp;
    bit exp_q[$];
    for (int r = 0; r < 16; r++) begin
      rmis = 0;
      nw = $urandom_range(10, 0);
      for (int i = 0; i < nw; i++) begin
        d = 1'($urandom_range(1, 0));
        if (wr_ready !== (model_q.size() < DEPTH)) rmis++;
        write_sym(d, rdy);
      end
      src = 1'($urandom_range(1, 0));
      if (!src) stop_k = $urandom_range(40, 1);
      else stop_k = ($urandom_range(1, 0) == 0) ? -1 : $urandom_range(US * DEPTH + 4, 1);
      qlen = model_q.size();
      exp_q.delete();
      if (!src) begin
        nexp = (stop_k - 1) / US + 1;
        uexp = 1'b0;
        for (int i = 0; i < nexp; i++) exp_q.push_back(prbs_sym(i));
      end else begin
        if (stop_k >= 1 && stop_k <= US * qlen) begin
          nexp = (stop_k - 1) / US + 1;
          uexp = 1'b0;
        end else begin
          nexp = qlen;
          uexp = 1'b1;
        end
        for (int i = 0; i < nexp; i++) exp_q.push_back(model_q.pop_front());
      end
      capture(src, stop_k, -1, 200);
      mis = 0;
      foreach (got_q[i]) if (i < nexp && got_q[i] !== exp_q[i]) mis++;
      total++;
      if (c_to || rmis !== 0 || got_q.size() !== nexp || mis !== 0) begin
        bad++;
        $display("FAIL rand%0d_syms got=%0d_syms/%0d_wrong/to%b/rdy%0d exp=%0d/0/0/0 src=%b stop=%0d", r, got_q.size(), mis, c_to, rmis, nexp, src, stop_k);
      end
      total++;
      if (c_en !== US * nexp || sym_count !== 16'(nexp) || underrun !== uexp || c_endk !== US * nexp + 1 || c_proto !== 0) begin
        bad++;
        $display("FAIL rand%0d_status got=en%0d/cnt%0d/ur%b/end%0d/proto%0d exp=%0d/%0d/%b/%0d/0", r, c_en, sym_count, underrun, c_endk, c_proto, US * nexp, nexp, uexp, US * nexp + 1);
      end
      for (int i = $urandom_range(2, 0); i > 0; i--) tick();
    end
  endtask

  initial begin
    test_reset();
    test_prbs_run();
    test_fifo_run();
    test_empty_start();
    test_full_fifo();
    test_stop_timing();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
